// File: rtl/ladder_input_image_if.sv
// Scan-engine side of the input process image: snapshot handshake plus frozen image outputs.
interface ladder_input_image_if #(
  parameter int N_IN = 8
);
  logic            scan_req;
  logic            clr_overrun;
  logic            scan_ack;
  logic [N_IN-1:0] img;
  logic [N_IN-1:0] img_rise;
  logic [N_IN-1:0] img_fall;
  logic            img_valid;
  logic            overrun;
  logic [15:0]     scan_count;

  modport master (
    output scan_req, clr_overrun,
    input  scan_ack, img, img_rise, img_fall, img_valid, overrun, scan_count
  );

  modport slave (
    input  scan_req, clr_overrun,
    output scan_ack, img, img_rise, img_fall, img_valid, overrun, scan_count
  );
endinterface

// File: rtl/ladder_input_image.sv
// Input process image: polarity fix, 2-FF sync, per-bit debounce, and a frozen
// per-scan snapshot with one-scan rise/fall bits.
//   state  | meaning
//   S_IDLE | waiting for scan_req; image held
//   S_ACK  | snapshot just taken, scan_ack high this cycle
module ladder_input_image #(
  parameter int              N_IN            = 8,
  parameter int              DEBOUNCE_CYCLES = 16,
  parameter logic [N_IN-1:0] INVERT_MASK     = '0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_IN-1:0]      i_raw_in,
  ladder_input_image_if.slave  s_if
);
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  logic [N_IN-1:0] r_sync1;
  logic [N_IN-1:0] r_sync2;
  logic [N_IN-1:0] r_deb;
  logic [CW-1:0]   r_cnt [N_IN];

  state_t          r_state;
  logic            r_scan_ack;
  logic [N_IN-1:0] r_img;
  logic [N_IN-1:0] r_img_rise;
  logic [N_IN-1:0] r_img_fall;
  logic            r_img_valid;
  logic            r_overrun;
  logic [15:0]     r_scan_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      for (int i = 0; i < N_IN; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= i_raw_in ^ INVERT_MASK;
      r_sync2 <= r_sync1;
      // any return to the accepted level restarts that bit's count
      for (int i = 0; i < N_IN; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_TC) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_scan_ack   <= 1'b0;
      r_img        <= '0;
      r_img_rise   <= '0;
      r_img_fall   <= '0;
      r_img_valid  <= 1'b0;
      r_overrun    <= 1'b0;
      r_scan_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_scan_ack <= 1'b0;
          if (s_if.clr_overrun) r_overrun <= 1'b0;
          if (s_if.scan_req) begin
            r_img        <= r_deb;
            r_img_rise   <= r_deb & ~r_img;
            r_img_fall   <= ~r_deb & r_img;
            r_img_valid  <= 1'b1;
            r_scan_count <= r_scan_count + 16'd1;
            r_scan_ack   <= 1'b1;
            r_state      <= S_ACK;
          end
        end
        S_ACK: begin
          r_scan_ack <= 1'b0;
          r_state    <= S_IDLE;
          // a request here is dropped; setting overrun wins over a clear
          if (s_if.scan_req)         r_overrun <= 1'b1;
          else if (s_if.clr_overrun) r_overrun <= 1'b0;
        end
        default: begin
          r_scan_ack <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign s_if.scan_ack   = r_scan_ack;
  assign s_if.img        = r_img;
  assign s_if.img_rise   = r_img_rise;
  assign s_if.img_fall   = r_img_fall;
  assign s_if.img_valid  = r_img_valid;
  assign s_if.overrun    = r_overrun;
  assign s_if.scan_count = r_scan_count;
endmodule

// File: tb/tb_ladder_input_image.sv
// Scoreboard bench for ladder_input_image: expected snapshots are queued when
// scan_req is driven and compared when scan_ack appears.
module tb_ladder_input_image;
  localparam logic [7:0] INV = 8'h0F;

  typedef struct packed {
    logic [7:0]  img;
    logic [7:0]  rise;
    logic [7:0]  fall;
    logic [15:0] cnt;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] raw_in;

  ladder_input_image_if #(.N_IN(8)) bus ();

  ladder_input_image #(
    .N_IN(8),
    .DEBOUNCE_CYCLES(16),
    .INVERT_MASK(INV)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_raw_in(raw_in),
    .s_if(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_ack    = 0;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [7:0] exp_img;
  logic [7:0] prev_img;
  logic [15:0] exp_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (bus.scan_ack === 1'b1) begin
      n_ack++;
      if (sb_q.size() == 0) begin
        check("unexpected_ack", 32'(bus.scan_ack), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("img",        32'(bus.img),        32'(mon_e.img));
        check("img_rise",   32'(bus.img_rise),   32'(mon_e.rise));
        check("img_fall",   32'(bus.img_fall),   32'(mon_e.fall));
        check("scan_count", 32'(bus.scan_count), 32'(mon_e.cnt));
        check("img_valid",  32'(bus.img_valid),  32'd1);
      end
    end
  end

  task automatic set_in(input logic [7:0] logical);
    raw_in = logical ^ INV;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_scan();
    exp_t t;
    exp_cnt  = exp_cnt + 16'd1;
    t.img    = exp_img;
    t.rise   = exp_img & ~prev_img;
    t.fall   = ~exp_img & prev_img;
    t.cnt    = exp_cnt;
    sb_q.push_back(t);
    prev_img = exp_img;
  endtask

  task automatic scan();
    expect_scan();
    bus.scan_req = 1'b1;
    @(negedge clk);
    bus.scan_req = 1'b0;
    @(negedge clk);
  endtask

  int a0;

  initial begin
    rst = 1'b1;
    raw_in = 8'hFF;
    bus.scan_req = 1'b0;
    bus.clr_overrun = 1'b0;
    prev_img = 8'h00;
    exp_cnt = 16'h0000;
    exp_img = 8'h00;

    wait_cyc(3);
    check("rst_img",        32'(bus.img),        32'd0);
    check("rst_rise",       32'(bus.img_rise),   32'd0);
    check("rst_fall",       32'(bus.img_fall),   32'd0);
    check("rst_valid",      32'(bus.img_valid),  32'd0);
    check("rst_overrun",    32'(bus.overrun),    32'd0);
    check("rst_scan_count", 32'(bus.scan_count), 32'd0);
    check("rst_ack",        32'(bus.scan_ack),   32'd0);

    // raw 0xFF with low nibble inverted reads as 0xF0
    rst = 1'b0;
    exp_img = 8'hF0;
    wait_cyc(20);
    scan();

    // debounce: short high burst, glitch low, then a clean high
    set_in(8'hF1);
    wait_cyc(8);
    scan();
    set_in(8'hF0);
    wait_cyc(2);
    set_in(8'hF1);
    wait_cyc(17);
    scan();
    exp_img = 8'hF1;
    scan();

    // edge bits across scans
    set_in(8'h00); exp_img = 8'h00; wait_cyc(20); scan();
    set_in(8'h05); exp_img = 8'h05; wait_cyc(20); scan();
    scan();
    set_in(8'h04); exp_img = 8'h04; wait_cyc(20); scan();

    // back-to-back request: one snapshot, overrun set
    a0 = n_ack;
    expect_scan();
    bus.scan_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.scan_req = 1'b0;
    wait_cyc(3);
    check("b2b_ack_count", 32'(n_ack - a0), 32'd1);
    check("b2b_overrun",   32'(bus.overrun), 32'd1);
    bus.clr_overrun = 1'b1;
    @(negedge clk);
    bus.clr_overrun = 1'b0;
    @(negedge clk);
    check("clr_overrun", 32'(bus.overrun), 32'd0);

    // clear in the same cycle as a dropped request: set wins
    expect_scan();
    bus.scan_req = 1'b1;
    @(negedge clk);
    bus.clr_overrun = 1'b1;
    @(negedge clk);
    bus.scan_req = 1'b0;
    bus.clr_overrun = 1'b0;
    @(negedge clk);
    check("set_beats_clr", 32'(bus.overrun), 32'd1);
    bus.clr_overrun = 1'b1;
    @(negedge clk);
    bus.clr_overrun = 1'b0;
    @(negedge clk);
    check("clr_after", 32'(bus.overrun), 32'd0);

    // wrap: jump the counter close to the top, then scan across it
    force dut.r_scan_count = 16'hFFFE;
    #1;
    release dut.r_scan_count;
    exp_cnt = 16'hFFFE;
    @(negedge clk);
    scan();
    scan();

    // reset asserted during the ACK cycle
    expect_scan();
    bus.scan_req = 1'b1;
    @(negedge clk);
    bus.scan_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midack_ack",   32'(bus.scan_ack),   32'd0);
    check("midack_count", 32'(bus.scan_count), 32'd0);
    check("midack_img",   32'(bus.img),        32'd0);
    check("midack_valid", 32'(bus.img_valid),  32'd0);
    rst = 1'b0;
    prev_img = 8'h00;
    exp_cnt = 16'h0000;
    exp_img = 8'h00;
    scan();
    exp_img = 8'h04;
    wait_cyc(20);
    scan();

    wait_cyc(4);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
